mod_sub_pipe: RTL and testbench
===============================

// Module: mod_sub_pipe
// PURPOSE
//   Two-stage pipelined modular subtractor: oData = (iData0 - iData1) mod iQ.
//   Inverse of the registered modular adder. Used in NTT/INTT butterflies and
//   RNS datapaths where a result is (a+b) mod q on one leg and (a-b) mod q on the other.
//   Valid/ready streaming on both sides, with pipeline stall, flush and range checking.
// PARAMETERS
//   BITWIDTH   32   operand, modulus and result width
// PORTS
//   iClk     in   1         clock, rising edge
//   iRstN    in   1         asynchronous active-low reset
//   iEn      in   1         global enable; 0 freezes pipeline
//   iClr     in   1         synchronous flush of all stages
//   iValid   in   1         input operands valid
//   oReady   out  1         block accepts input this cycle
//   iData0   in   BITWIDTH  minuend a, expected < iQ
//   iData1   in   BITWIDTH  subtrahend b, expected < iQ
//   iQ       in   BITWIDTH  modulus, sampled with operands
//   oValid   out  1         result valid
//   iReady   in   1         downstream accepts result
//   oData    out  BITWIDTH  (a - b) mod q
//   oErr     out  1         paired with oData: a>=q or b>=q for this result
// BEHAVIOUR
//   Reset (iRstN=0, async): all valid bits 0; data, q and err regs 0.
//     Outputs: oValid=0, oData=0, oErr=0, oReady=0 while reset is asserted.
//   Input transfer: iValid && oReady. Output transfer: oValid && iReady.
//   Stage S1 captures on input transfer:
//     d = {1'b0,a} - {1'b0,b} (BITWIDTH+1 bits), borrow = d[BITWIDTH], q, err.
//   Stage S2 result:
//     borrow ? (d[BITWIDTH-1:0] + q) mod 2^BITWIDTH : d[BITWIDTH-1:0].
//     Also holds err.
//   Advance rules:
//     s2_adv = !s2_valid || iReady
//     s1_adv = !s1_valid || s2_adv
//     oReady = iEn && !iClr && s1_adv   (combinational; no combinational path iValid->oReady)
//   Latency: 2 cycles from input transfer to oValid, with no stall.
//   Throughput: 1 result per cycle at full rate.
//   Stall: while oValid && !iReady, oData and oErr hold stable.
//     S1 fills, then oReady drops. No data lost or duplicated; order preserved.
//   iEn=0: all registers hold; oValid forced 0; oReady=0; iReady ignored.
//     When iEn returns to 1, the held contents reappear unchanged.
//   iClr=1 (sync; priority over iEn and handshakes): next edge clears valids, data, err.
//     The input offered in the iClr cycle is not accepted.
//   Simultaneous input and output transfer in one cycle: both occur; the pipe shifts.
//   Out-of-range input (a>=q or b>=q): data is computed by the same formula, no saturation.
//     oErr=1 with that result only.
//   Boundary cases:
//     q=0: every input raises err.
//     a==b: result 0, no borrow.
//     a=0, b=q-1: result 1.
//   iQ may change every transaction; each result uses its own sampled q.
//   Reset mid-operation: in-flight data is discarded; no partial output.
// TESTING  (BITWIDTH=32 unless noted)
//   1. q=17: (a,b) = (10,3), (3,10), (0,16), (5,5), fed back-to-back, iReady=1
//      -> results 7, 10, 1, 0 on 4 consecutive cycles, starting 2 cycles after the first transfer; oErr=0.
//   2. Backpressure: stream 1..8 minus 0 (q=97) with iReady toggling pseudo-randomly
//      -> oData sequence 1..8 in order; output stable while stalled;
//         oReady=0 only when S1 and S2 are full and iReady=0.
//   3. q=2^32-1: a=0, b=2^32-2 -> 1. Check wrap in the d+q add.
//      Also a=q (out of range), b=0 -> oData=2^32-1 with oErr=1.
//   4. Fill the pipe with 2 items, assert iClr for 1 cycle with iValid=1
//      -> oValid=0 next cycle; iClr-cycle input dropped; a new transfer yields a result 2 cycles later.
//   5. iEn=0 for 3 cycles with 2 items in flight -> oValid=0, oReady=0;
//      on re-enable the items emerge in order, values unchanged.
//   6. Assert iRstN low mid-stream, asynchronously between edges
//      -> oValid and oData go to 0 immediately; after release no stale results appear.
//      Random compare versus a reference model over 10k vectors with q in [1, 2^32-1].

Source files
------------

// File: rtl/mod_sub_pipe.sv
// -----------------------------------------------------------------------------
// mod_sub_pipe
//   Two-stage pipelined modular subtractor: oData = (iData0 - iData1) mod iQ.
//   Companion of the registered modular adder in NTT/INTT butterflies and RNS
//   datapaths. Valid/ready streaming on both sides with stall, enable-freeze,
//   synchronous flush and an out-of-range flag that travels with each result.
//
// Ports
//   iClk     in   clock, rising edge
//   iRstN    in   asynchronous active-low reset
//   iEn      in   global enable; 0 freezes every register and hides oValid
//   iClr     in   synchronous flush of both stages (beats iEn and handshakes)
//   iValid   in   operands valid
//   oReady   out  operands accepted this cycle (combinational, no iValid path)
//   iData0   in   minuend a, expected < iQ
//   iData1   in   subtrahend b, expected < iQ
//   iQ       in   modulus, sampled together with the operands
//   oValid   out  result valid
//   iReady   in   downstream accepts the result
//   oData    out  (a - b) mod q
//   oErr     out  a >= q or b >= q for the result currently on oData
// -----------------------------------------------------------------------------
module mod_sub_pipe #(
  parameter int BITWIDTH = 32
) (
  input  logic                iClk,
  input  logic                iRstN,
  input  logic                iEn,
  input  logic                iClr,
  input  logic                iValid,
  output logic                oReady,
  input  logic [BITWIDTH-1:0] iData0,
  input  logic [BITWIDTH-1:0] iData1,
  input  logic [BITWIDTH-1:0] iQ,
  output logic                oValid,
  input  logic                iReady,
  output logic [BITWIDTH-1:0] oData,
  output logic                oErr
);

  localparam int W = BITWIDTH;

  // Stage 1: widened difference (MSB is the borrow), sampled modulus, range flag
  logic         s1Valid_q, s1Valid_d;
  logic [W:0]   s1Diff_q,  s1Diff_d;
  logic [W-1:0] s1Mod_q,   s1Mod_d;
  logic         s1Err_q,   s1Err_d;

  // Stage 2: final result and its range flag
  logic         s2Valid_q, s2Valid_d;
  logic [W-1:0] s2Data_q,  s2Data_d;
  logic         s2Err_q,   s2Err_d;

  logic s2Adv;
  logic s1Adv;
  logic inXfer;

  // A stage may take new contents when it is empty or its occupant moves on.
  // oReady is gated by iRstN so that it reads 0 for the whole reset period.
  always_comb begin
    s2Adv  = !s2Valid_q || iReady;
    s1Adv  = !s1Valid_q || s2Adv;
    oReady = iRstN && iEn && !iClr && s1Adv;
    inXfer = iValid && oReady;
  end

  // Next-state for both stages. Flush wins over everything; with iEn low all
  // state simply holds. Data fields only load when a valid item arrives so a
  // stalled or drained result stays stable on oData.
  always_comb begin
    s1Valid_d = s1Valid_q;
    s1Diff_d  = s1Diff_q;
    s1Mod_d   = s1Mod_q;
    s1Err_d   = s1Err_q;
    s2Valid_d = s2Valid_q;
    s2Data_d  = s2Data_q;
    s2Err_d   = s2Err_q;

    if (iClr) begin
      s1Valid_d = 1'b0;
      s1Diff_d  = '0;
      s1Mod_d   = '0;
      s1Err_d   = 1'b0;
      s2Valid_d = 1'b0;
      s2Data_d  = '0;
      s2Err_d   = 1'b0;
    end else if (iEn) begin
      if (s2Adv) begin
        s2Valid_d = s1Valid_q;
        if (s1Valid_q) begin
          // On borrow, adding q back wraps modulo 2^W by design
          s2Data_d = s1Diff_q[W] ? (s1Diff_q[W-1:0] + s1Mod_q) : s1Diff_q[W-1:0];
          s2Err_d  = s1Err_q;
        end
      end
      if (s1Adv) begin
        s1Valid_d = inXfer;
        if (inXfer) begin
          s1Diff_d = {1'b0, iData0} - {1'b0, iData1};
          s1Mod_d  = iQ;
          s1Err_d  = (iData0 >= iQ) || (iData1 >= iQ);
        end
      end
    end
  end

  always_ff @(posedge iClk or negedge iRstN) begin
    if (!iRstN) begin
      s1Valid_q <= 1'b0;
      s1Diff_q  <= '0;
      s1Mod_q   <= '0;
      s1Err_q   <= 1'b0;
      s2Valid_q <= 1'b0;
      s2Data_q  <= '0;
      s2Err_q   <= 1'b0;
    end else begin
      s1Valid_q <= s1Valid_d;
      s1Diff_q  <= s1Diff_d;
      s1Mod_q   <= s1Mod_d;
      s1Err_q   <= s1Err_d;
      s2Valid_q <= s2Valid_d;
      s2Data_q  <= s2Data_d;
      s2Err_q   <= s2Err_d;
    end
  end

  // The result is hidden while frozen but stays in S2 for when iEn returns
  always_comb begin
    oValid = iEn && s2Valid_q;
    oData  = s2Data_q;
    oErr   = s2Err_q;
  end

endmodule

// File: tb/tb_mod_sub_pipe.sv
module tb_mod_sub_pipe;

  logic        iClk = 1'b0;
  logic        iRstN;
  logic        iEn;
  logic        iClr;
  logic        iValid;
  logic        oReady;
  logic [31:0] iData0;
  logic [31:0] iData1;
  logic [31:0] iQ;
  logic        oValid;
  logic        iReady;
  logic [31:0] oData;
  logic        oErr;

  always #5 iClk = ~iClk;

  mod_sub_pipe #(.BITWIDTH(32)) dut (
    .iClk   (iClk),
    .iRstN  (iRstN),
    .iEn    (iEn),
    .iClr   (iClr),
    .iValid (iValid),
    .oReady (oReady),
    .iData0 (iData0),
    .iData1 (iData1),
    .iQ     (iQ),
    .oValid (oValid),
    .iReady (iReady),
    .oData  (oData),
    .oErr   (oErr)
  );

  typedef struct {
    logic [31:0] data;
    logic        err;
  } res_t;

  // Items accepted but not yet delivered, oldest first
  res_t expQ[$];
  // Every result actually delivered, for directed value checks
  res_t outLog[$];

  int vectors     = 0;
  int miscompares = 0;

  logic        sValid;
  logic [31:0] sData;
  logic        sAccepted;
  logic        stallPrev = 1'b0;
  logic [31:0] stallData = '0;
  logic        stallErr  = 1'b0;

  // Reference rule: the mathematical difference when it is non-negative,
  // otherwise the difference plus q reduced modulo 2^32
  function automatic res_t refSub(input logic [31:0] a, input logic [31:0] b,
                                  input logic [31:0] q);
    res_t r;
    longint unsigned diff;
    if (a >= b) diff = longint'(a) - longint'(b);
    else        diff = (longint'(a) + longint'(q) - longint'(b)) % 64'h1_0000_0000;
    r.data = diff[31:0];
    r.err  = (a >= q) || (b >= q);
    return r;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs,
                             input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock cycle, entered and left at a falling edge: drive, sample,
  // score the handshakes against the queue model, then advance.
  task automatic applyStimulus(input logic v, input logic [31:0] a,
                               input logic [31:0] b, input logic [31:0] q,
                               input logic rdy, input logic en, input logic clr);
    res_t  e;
    logic  expReady;
    iValid = v;
    iData0 = a;
    iData1 = b;
    iQ     = q;
    iReady = rdy;
    iEn    = en;
    iClr   = clr;
    #1;
    sValid    = oValid;
    sData     = oData;
    sAccepted = v && oReady;

    // Input is refused only when both stages hold items and nothing drains
    expReady = en && !clr && !(expQ.size() == 2 && !rdy);
    checkOutput("oReady", {31'b0, oReady}, {31'b0, expReady});
    if (!en) checkOutput("oValid_frozen", {31'b0, oValid}, 32'd0);
    if (oValid && expQ.size() == 0) checkOutput("spurious_valid", {31'b0, oValid}, 32'd0);

    if (stallPrev && en && !clr) begin
      checkOutput("stall_valid", {31'b0, oValid}, 32'd1);
      checkOutput("stall_data", oData, stallData);
      checkOutput("stall_err", {31'b0, oErr}, {31'b0, stallErr});
    end

    if (oValid && rdy && en && !clr && expQ.size() != 0) begin
      e = expQ.pop_front();
      checkOutput("result_data", oData, e.data);
      checkOutput("result_err", {31'b0, oErr}, {31'b0, e.err});
      e.data = oData;
      e.err  = oErr;
      outLog.push_back(e);
    end

    if (en && !clr) begin
      stallPrev = oValid && !rdy;
      stallData = oData;
      stallErr  = oErr;
    end
    if (sAccepted) expQ.push_back(refSub(a, b, q));
    if (clr) begin
      expQ.delete();
      stallPrev = 1'b0;
    end
    @(posedge iClk);
    @(negedge iClk);
  endtask

  task automatic drain();
    for (int i = 0; i < 40 && expQ.size() != 0; i++)
      applyStimulus(1'b0, 32'd0, 32'd0, 32'd1, 1'b1, 1'b1, 1'b0);
    checkOutput("drain_empty", expQ.size(), 32'd0);
    applyStimulus(1'b0, 32'd0, 32'd0, 32'd1, 1'b1, 1'b1, 1'b0);
  endtask

  initial begin
    logic        vldSeq [7];
    logic [31:0] exp1 [4];
    int          accepted;
    logic [31:0] a, b, q;

    // Reset state
    iRstN = 1'b0; iEn = 1'b1; iClr = 1'b0; iValid = 1'b1; iReady = 1'b1;
    iData0 = 32'd9; iData1 = 32'd2; iQ = 32'd17;
    #3;
    checkOutput("rst_oValid", {31'b0, oValid}, 32'd0);
    checkOutput("rst_oData", oData, 32'd0);
    checkOutput("rst_oErr", {31'b0, oErr}, 32'd0);
    checkOutput("rst_oReady", {31'b0, oReady}, 32'd0);
    @(negedge iClk);
    iRstN = 1'b1;

    // Back-to-back q=17, latency 2, full rate
    outLog.delete();
    exp1[0] = 32'd7; exp1[1] = 32'd10; exp1[2] = 32'd1; exp1[3] = 32'd0;
    applyStimulus(1'b1, 32'd10, 32'd3, 32'd17, 1'b1, 1'b1, 1'b0); vldSeq[0] = sValid;
    applyStimulus(1'b1, 32'd3, 32'd10, 32'd17, 1'b1, 1'b1, 1'b0); vldSeq[1] = sValid;
    applyStimulus(1'b1, 32'd0, 32'd16, 32'd17, 1'b1, 1'b1, 1'b0); vldSeq[2] = sValid;
    applyStimulus(1'b1, 32'd5, 32'd5, 32'd17, 1'b1, 1'b1, 1'b0);  vldSeq[3] = sValid;
    for (int i = 4; i < 7; i++) begin
      applyStimulus(1'b0, 32'd0, 32'd0, 32'd17, 1'b1, 1'b1, 1'b0);
      vldSeq[i] = sValid;
    end
    for (int i = 0; i < 7; i++)
      checkOutput($sformatf("t1_valid_c%0d", i), {31'b0, vldSeq[i]},
                  (i >= 2 && i <= 5) ? 32'd1 : 32'd0);
    checkOutput("t1_count", outLog.size(), 32'd4);
    for (int i = 0; i < 4 && i < outLog.size(); i++) begin
      checkOutput($sformatf("t1_data%0d", i), outLog[i].data, exp1[i]);
      checkOutput($sformatf("t1_err%0d", i), {31'b0, outLog[i].err}, 32'd0);
    end

    // Backpressure: 1..8 with iReady toggling
    outLog.delete();
    accepted = 0;
    for (int g = 0; g < 200 && accepted < 8; g++) begin
      applyStimulus(1'b1, accepted + 1, 32'd0, 32'd97, 1'($urandom_range(0, 1)), 1'b1, 1'b0);
      if (sAccepted) accepted++;
    end
    checkOutput("t2_accepted", accepted, 32'd8);
    drain();
    checkOutput("t2_count", outLog.size(), 32'd8);
    for (int i = 0; i < 8 && i < outLog.size(); i++)
      checkOutput($sformatf("t2_order%0d", i), outLog[i].data, i + 1);

    // Wrap in the d+q add, out-of-range and q=0 cases
    outLog.delete();
    applyStimulus(1'b1, 32'd0, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 1'b1, 1'b1, 1'b0);
    applyStimulus(1'b1, 32'hFFFF_FFFF, 32'd0, 32'hFFFF_FFFF, 1'b1, 1'b1, 1'b0);
    applyStimulus(1'b1, 32'd5, 32'd3, 32'd0, 1'b1, 1'b1, 1'b0);
    applyStimulus(1'b1, 32'd3, 32'd5, 32'd0, 1'b1, 1'b1, 1'b0);
    drain();
    checkOutput("t3_count", outLog.size(), 32'd4);
    if (outLog.size() == 4) begin
      checkOutput("t3_wrap_data", outLog[0].data, 32'd1);
      checkOutput("t3_wrap_err", {31'b0, outLog[0].err}, 32'd0);
      checkOutput("t3_oor_data", outLog[1].data, 32'hFFFF_FFFF);
      checkOutput("t3_oor_err", {31'b0, outLog[1].err}, 32'd1);
      checkOutput("t3_q0_data", outLog[2].data, 32'd2);
      checkOutput("t3_q0_err", {31'b0, outLog[2].err}, 32'd1);
      checkOutput("t3_q0b_data", outLog[3].data, 32'hFFFF_FFFE);
      checkOutput("t3_q0b_err", {31'b0, outLog[3].err}, 32'd1);
    end

    // Flush with two items in flight; the iClr-cycle input is dropped
    outLog.delete();
    applyStimulus(1'b1, 32'd20, 32'd1, 32'd31, 1'b0, 1'b1, 1'b0);
    applyStimulus(1'b1, 32'd21, 32'd1, 32'd31, 1'b0, 1'b1, 1'b0);
    applyStimulus(1'b1, 32'd22, 32'd1, 32'd31, 1'b0, 1'b1, 1'b1);
    applyStimulus(1'b1, 32'd9, 32'd4, 32'd31, 1'b1, 1'b1, 1'b0);
    checkOutput("t4_valid_after_clr", {31'b0, sValid}, 32'd0);
    applyStimulus(1'b0, 32'd0, 32'd0, 32'd31, 1'b1, 1'b1, 1'b0);
    checkOutput("t4_valid_c1", {31'b0, sValid}, 32'd0);
    applyStimulus(1'b0, 32'd0, 32'd0, 32'd31, 1'b1, 1'b1, 1'b0);
    checkOutput("t4_valid_c2", {31'b0, sValid}, 32'd1);
    checkOutput("t4_data", sData, 32'd5);
    drain();
    checkOutput("t4_count", outLog.size(), 32'd1);

    // Freeze with two items in flight
    outLog.delete();
    applyStimulus(1'b1, 32'd4, 32'd9, 32'd13, 1'b0, 1'b1, 1'b0);
    applyStimulus(1'b1, 32'd12, 32'd2, 32'd13, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++)
      applyStimulus(1'b1, 32'd7, 32'd1, 32'd13, 1'b1, 1'b0, 1'b0);
    drain();
    checkOutput("t5_count", outLog.size(), 32'd2);
    if (outLog.size() == 2) begin
      checkOutput("t5_first", outLog[0].data, 32'd8);
      checkOutput("t5_second", outLog[1].data, 32'd10);
    end

    // Asynchronous reset between edges with a full pipe
    applyStimulus(1'b1, 32'd1, 32'd2, 32'd3, 1'b0, 1'b1, 1'b0);
    applyStimulus(1'b1, 32'd2, 32'd1, 32'd3, 1'b0, 1'b1, 1'b0);
    iValid = 1'b0; iReady = 1'b0;
    #2;
    iRstN = 1'b0;
    #1;
    checkOutput("t6_oValid", {31'b0, oValid}, 32'd0);
    checkOutput("t6_oData", oData, 32'd0);
    checkOutput("t6_oErr", {31'b0, oErr}, 32'd0);
    checkOutput("t6_oReady", {31'b0, oReady}, 32'd0);
    expQ.delete();
    stallPrev = 1'b0;
    @(negedge iClk);
    #2;
    iRstN = 1'b1;
    @(negedge iClk);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b0, 32'd0, 32'd0, 32'd3, 1'b1, 1'b1, 1'b0);
      checkOutput($sformatf("t6_no_stale%0d", i), {31'b0, sValid}, 32'd0);
    end

    // Random traffic against the queue model
    for (int i = 0; i < 10000; i++) begin
      q = $urandom();
      if ($urandom_range(0, 3) == 0) q = $urandom_range(1, 64);
      if (q == 32'd0) q = 32'd1;
      a = $urandom() % q;
      b = $urandom() % q;
      if ($urandom_range(0, 15) == 0) a = $urandom();
      if ($urandom_range(0, 15) == 0) b = $urandom();
      applyStimulus(1'($urandom_range(0, 3) != 0), a, b, q,
                    1'($urandom_range(0, 3) != 0),
                    1'($urandom_range(0, 19) != 0),
                    1'($urandom_range(0, 199) == 0));
    end
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
